psdsqrt_sched: RTL and testbench
================================

Name: psdsqrt_sched

Overview:
- Round-robin scheduler that shares one psdsqrt square-root core between NREQ independent requesters.
- Arbitrates pending requests and captures the winner's operand.
- Sequences the core's start and stop pulses over the required iteration count.
- Returns the rounded result to the granted requester with a one-cycle done pulse.
- Sits between the requesting blocks and a single psdsqrt instance.

Parameters:
- NBITSIN, 16, operand width; must equal the core's NBITSIN (even, >= 4).
- NREQ, 4, number of requesters (2..8).
- ITERS, NBITSIN/2+4, compute cycles between core start and core stop (one per result bit, including 4 fraction bits).

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous reset, active high.
- req  in  NREQ  level request per requester.
- xin_bus  in  NREQ*NBITSIN  packed operands; requester k occupies bits [k*NBITSIN +: NBITSIN].
- done  out  NREQ  one-cycle completion pulse, one-hot.
- result  out  NBITSIN/2  rounded sqrt; valid in the cycle done is high, held until the next completion.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- core_start  out  1  to core start.
- core_stop  out  1  to core stop.
- core_xin  out  NBITSIN  to core xin; registered.
- core_sqrt  in  NBITSIN/2  from core sqrt.

Behaviour:
- Reset (async, active high) forces:
  - state IDLE, rr pointer 0, count 0;
  - done, result, busy, grant_id, core_start, core_stop, core_xin all 0.
- States: IDLE -> START -> COMPUTE -> STOP -> DONE -> IDLE. All outputs are registered or decoded from state only; no combinational path from req to any output.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - At that edge: latch grant_id and core_xin <= the winner's operand; go to START.
  - No request: stay in IDLE.
- START: core_start=1 for exactly one cycle; count <= 0; go to COMPUTE.
- COMPUTE:
  - Lasts exactly ITERS cycles; count increments each cycle.
  - Go to STOP when count == ITERS-1.
- STOP: core_stop=1 for exactly one cycle. The core registers sqrt at this edge.
- DONE:
  - result <= core_sqrt; done[grant_id] <= 1, so the pulse and result are visible in the following cycle.
  - rr pointer <= (grant_id+1) mod NREQ; go to IDLE.
- Latency: req sampled in IDLE cycle T -> done high in cycle T+ITERS+4. This is 16 cycles at defaults.
- Back-to-back throughput: one result per ITERS+4 cycles. Arbitration in IDLE happens in the same cycle the previous done is high.
- Operand capture: the operand is captured at grant; the requester may change xin after grant.
- req sampling:
  - req is sampled only in IDLE; dropping req before grant withdraws the request.
  - After grant, req is ignored until done.
  - A requester must drop req in its done cycle. If it does not, it is treated as a new request, but only after the round-robin pointer has passed it.
- Fairness: with all NREQ requests held, grants go 0,1,..,NREQ-1,0,…; no requester waits more than NREQ-1 services.
- core_xin holds its value outside START. Only core_start and core_stop are pulses.
- Reset mid-operation:
  - Returns to IDLE immediately; no done is emitted for the aborted job.
  - core_start and core_stop drop to 0.
  - The core need not be reset: the next START reinitialises it.
- Simultaneous events: new req bits arriving in a non-IDLE state wait. The result of a job in flight is unaffected.
- Result overflow (e.g. xin=65535 rounding to 256) wraps as the core does. The scheduler does not saturate.

Test Plan:
- Single request, xin=144 on req[0] in IDLE at cycle T -> core_start high at T+1, core_stop high at T+14, done=0001 and result=12 at T+16; busy high T+1..T+15.
- Rounding through the scheduler -> xin=7 gives 3; xin=6 gives 2; xin=2 gives 1; xin=65025 gives 255.
- All four req held with xin {4,9,16,25} -> done order 0,1,2,3,0 with results 2,3,4,5; grants spaced 16 cycles apart; done never more than one-hot.
- Withdrawal: req[2] raised and dropped while busy serving req[1] -> no grant or done for requester 2; scheduler idles after requester 1.
- Async reset asserted mid-COMPUTE -> all outputs 0 within the same cycle, no done pulse. A new req[3] (xin=100) after release -> result=10 with normal latency.
- Operand changed the cycle after grant -> result reflects the operand captured at grant.

Source files
------------

// File: rtl/psdsqrt_sched.sv
// psdsqrt_sched: round-robin scheduler sharing one psdsqrt square-root core
// between NREQ requesters.
//
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   req            - level request per requester (sampled only while idle)
//   xin_bus        - packed operands, requester k at [k*NBITSIN +: NBITSIN]
//   done           - one-hot, one-cycle completion pulse
//   result         - rounded sqrt, valid with done, held until next completion
//   busy           - high whenever the sequencer is not idle
//   grant_id       - current or last granted requester
//   core_start     - one-cycle start pulse to the core
//   core_stop      - one-cycle stop pulse to the core
//   core_xin       - operand to the core, captured at grant
//   core_sqrt      - result from the core
module psdsqrt_sched #(
    parameter int NBITSIN = 16,
    parameter int NREQ    = 4,
    parameter int ITERS   = NBITSIN / 2 + 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*NBITSIN-1:0]     xin_bus,
    output logic [NREQ-1:0]             done,
    output logic [NBITSIN/2-1:0]        result,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     grant_id,
    output logic                        core_start,
    output logic                        core_stop,
    output logic [NBITSIN-1:0]          core_xin,
    input  logic [NBITSIN/2-1:0]        core_sqrt
);

    localparam int IDW  = $clog2(NREQ);
    localparam int IDW1 = IDW + 1;
    localparam int CW   = $clog2(ITERS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COMPUTE,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 state_q,  state_d;
    logic [IDW-1:0]         ptr_q,    ptr_d;
    logic [CW-1:0]          count_q,  count_d;
    logic [NREQ-1:0]        done_q,   done_d;
    logic [NBITSIN/2-1:0]   result_q, result_d;
    logic                   busy_q,   busy_d;
    logic [IDW-1:0]         grant_q,  grant_d;
    logic                   start_q,  start_d;
    logic                   stop_q,   stop_d;
    logic [NBITSIN-1:0]     xin_q,    xin_d;

    // Round-robin arbitration: first set req bit at or above ptr_q, wrapping.
    logic                   found;
    logic [IDW-1:0]         win;
    logic [IDW1-1:0]        sum;
    logic [NBITSIN-1:0]     win_xin;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + IDW1'(i);
            if (sum >= IDW1'(NREQ)) begin
                sum = sum - IDW1'(NREQ);
            end
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!found && req[k] && (sum[IDW-1:0] == IDW'(k))) begin
                    found = 1'b1;
                    win   = IDW'(k);
                end
            end
        end
        win_xin = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win == IDW'(k)) begin
                win_xin = xin_bus[k*NBITSIN +: NBITSIN];
            end
        end
    end

    // Next-state logic. Pulse outputs are registered one edge early so that
    // they line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        done_d   = '0;
        result_d = result_q;
        grant_d  = grant_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        xin_d    = xin_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = win;
                    xin_d   = win_xin;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                count_d = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                count_d = count_q + CW'(1);
                if (count_q == CW'(ITERS - 1)) begin
                    stop_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                result_d         = core_sqrt;
                done_d[grant_q]  = 1'b1;
                ptr_d            = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            grant_q  <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            xin_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            xin_q    <= xin_d;
        end
    end

    assign done       = done_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign core_start = start_q;
    assign core_stop  = stop_q;
    assign core_xin   = xin_q;

endmodule

// File: tb/tb_psdsqrt_sched.sv
module tb_psdsqrt_sched;

    localparam int NB = 16;
    localparam int NR = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*NB-1:0]  xin_bus = '0;
    logic [NR-1:0]     done;
    logic [NB/2-1:0]   result;
    logic              busy;
    logic [1:0]        grant_id;
    logic              core_start;
    logic              core_stop;
    logic [NB-1:0]     core_xin;
    logic [NB/2-1:0]   core_sqrt = '0;

    int tests = 0;
    int fails = 0;

    int         exp_id[$];
    logic [7:0] exp_res[$];

    psdsqrt_sched #(.NBITSIN(NB), .NREQ(NR)) dut (
        .clock(clock), .reset(reset), .req(req), .xin_bus(xin_bus),
        .done(done), .result(result), .busy(busy), .grant_id(grant_id),
        .core_start(core_start), .core_stop(core_stop), .core_xin(core_xin),
        .core_sqrt(core_sqrt)
    );

    always #5 clock = ~clock;

    // Behavioural stand-in for the psdsqrt core: latches xin on start,
    // presents the rounded (8-bit wrapped) square root after stop.
    function automatic logic [7:0] rsqrt(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        if (x > r * r + r) r++;
        return r[7:0];
    endfunction

    logic [NB-1:0] core_op = '0;
    always @(posedge clock) begin
        if (core_start) core_op <= core_xin;
        if (core_stop)  core_sqrt <= rsqrt(core_op);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clock) begin
        if (!reset && done !== '0) begin
            if (exp_id.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                int         id;
                logic [7:0] r;
                id = exp_id.pop_front();
                r  = exp_res.pop_front();
                chk("done_onehot", 32'(done), 32'(1 << id));
                chk("result", 32'(result), 32'(r));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_x(input int k, input logic [NB-1:0] x);
        xin_bus[k*NB +: NB] = x;
    endtask

    // Request from one requester in an idle cycle and check 16-cycle latency.
    task automatic run_single(input int k, input logic [NB-1:0] x,
                              input logic [7:0] r, input bit change);
        int cnt;
        set_x(k, x);
        req[k] = 1'b1;
        exp_id.push_back(k);
        exp_res.push_back(r);
        tick();
        req[k] = 1'b0;
        if (change) set_x(k, ~x);
        cnt = 1;
        while (done === '0 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("latency", 32'(cnt), 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int starts;
        int last_cyc;
        int cyc;
        int busy_seen;
        int order[5];
        order = '{0, 1, 2, 3, 0};

        // Reset state
        tick(); tick();
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_start", 32'(core_start), 0);
        chk("rst_stop", 32'(core_stop), 0);
        chk("rst_xin", 32'(core_xin), 0);
        reset = 1'b0;
        tick();

        // Single request with detailed per-cycle timing
        set_x(0, 16'd144);
        req[0] = 1'b1;
        exp_id.push_back(0);
        exp_res.push_back(8'd12);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin
                req[0] = 1'b0;
                chk("t1_grant", 32'(grant_id), 0);
                chk("t1_xin", 32'(core_xin), 144);
            end
            chk($sformatf("t1_start_c%0d", k), 32'(core_start), 32'(k == 1));
            chk($sformatf("t1_stop_c%0d", k), 32'(core_stop), 32'(k == 14));
            chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 15));
            chk($sformatf("t1_done_c%0d", k), 32'(done), (k == 16) ? 1 : 0);
        end

        // Rounding through the scheduler
        run_single(1, 16'd7, 8'd3, 0);
        run_single(2, 16'd6, 8'd2, 0);
        run_single(3, 16'd2, 8'd1, 0);
        run_single(0, 16'd65025, 8'd255, 0);

        // Reset pointer, then hold all four requests
        reset = 1'b1; tick(); reset = 1'b0; tick();
        set_x(0, 16'd4); set_x(1, 16'd9); set_x(2, 16'd16); set_x(3, 16'd25);
        exp_id  = '{0, 1, 2, 3, 0};
        exp_res = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd2};
        req = 4'b1111;
        starts = 0; last_cyc = 0; cyc = 0;
        while (starts < 5 && cyc < 120) begin
            tick();
            cyc++;
            if (core_start) begin
                chk($sformatf("rr_grant%0d", starts), 32'(grant_id), 32'(order[starts]));
                if (starts > 0) chk("rr_spacing", 32'(cyc - last_cyc), 16);
                last_cyc = cyc;
                starts++;
                if (starts == 5) req = '0;
            end
        end
        chk("rr_starts", 32'(starts), 5);
        cyc = 0;
        while (exp_id.size() != 0 && cyc < 40) begin tick(); cyc++; end
        chk("rr_drained", 32'(exp_id.size()), 0);

        // Withdrawal: req[2] raised and dropped while serving requester 1
        tick();
        set_x(1, 16'd81);
        req[1] = 1'b1;
        exp_id.push_back(1);
        exp_res.push_back(8'd9);
        tick();
        req[1] = 1'b0;
        set_x(2, 16'd36);
        req[2] = 1'b1;
        repeat (5) tick();
        req[2] = 1'b0;
        cyc = 0;
        while (done === '0 && cyc < 40) begin tick(); cyc++; end
        busy_seen = 0;
        repeat (30) begin tick(); if (busy) busy_seen++; end
        chk("wd_idle", 32'(busy_seen), 0);
        chk("wd_grant", 32'(grant_id), 1);

        // Asynchronous reset mid-COMPUTE, no done for the aborted job
        set_x(2, 16'd50);
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        chk("ar_done", 32'(done), 0);
        chk("ar_result", 32'(result), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_grant", 32'(grant_id), 0);
        chk("ar_start", 32'(core_start), 0);
        chk("ar_stop", 32'(core_stop), 0);
        chk("ar_xin", 32'(core_xin), 0);
        tick();
        reset = 1'b0;
        tick();
        run_single(3, 16'd100, 8'd10, 0);

        // Operand changed after grant; then overflow wrap
        run_single(1, 16'd400, 8'd20, 1);
        run_single(2, 16'd65535, 8'd0, 0);

        repeat (3) tick();
        chk("sb_empty", 32'(exp_id.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
